// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer: streams an 8-byte A/B job into the matrix controller,
// waits for done (with timeout), then streams the four result bytes out.
module tpu_host_sequencer #(
  parameter int DATA_W       = 8,
  parameter int N_ELEM       = 4,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ctrl_rst,
  output logic              load_en,
  output logic              load_sel_ab,
  output logic [1:0]        load_index,
  output logic [DATA_W-1:0] in_data,
  input  logic              done,
  output logic              output_en,
  output logic [1:0]        output_sel,
  input  logic [DATA_W-1:0] out_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              timeout
);

  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int CNT_W  = IDX_W + 1;
  localparam int TCNT_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(2 * N_ELEM - 1);
  localparam logic [IDX_W-1:0]  RIDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(DONE_TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLR       = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RD_SEL    = 3'd4;
  localparam logic [2:0] S_RD_OUT    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              s_ready_q, s_ready_d;
  logic              ctrl_rst_q, ctrl_rst_d;
  logic              load_en_q, load_en_d;
  logic              load_sel_q, load_sel_d;
  logic [IDX_W-1:0]  load_index_q, load_index_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              output_en_q, output_en_d;
  logic [IDX_W-1:0]  output_sel_q, output_sel_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  // Next-state, counters and datapath; every output is a registered function of state_d.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    ridx_d       = ridx_q;
    timeout_d    = timeout_q;
    m_data_d     = m_data_q;
    load_en_d    = 1'b0;
    load_sel_d   = load_sel_q;
    load_index_d = load_index_q;
    in_data_d    = in_data_q;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          state_d   = S_CLR;
          timeout_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_CLR: begin
        cnt_d   = {CNT_W{1'b0}};
        ridx_d  = {IDX_W{1'b0}};
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (s_valid && s_ready_q) begin
          load_en_d    = 1'b1;
          in_data_d    = s_data;
          load_sel_d   = cnt_q[CNT_W-1];
          load_index_d = cnt_q[IDX_W-1:0];
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_WAIT_DONE;
            tcnt_d  = {TCNT_W{1'b0}};
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT_DONE: begin
        // done takes priority over an expiring timeout in the same cycle
        if (done) begin
          state_d = S_RD_SEL;
          ridx_d  = {IDX_W{1'b0}};
        end else if (tcnt_q == TCNT_MAX) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_RD_SEL: begin
        m_data_d = out_data;
        state_d  = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (m_valid_q && m_ready) begin
          if (ridx_q == RIDX_LAST) begin
            state_d = S_IDLE;
          end else begin
            ridx_d  = ridx_q + IDX_W'(1);
            state_d = S_RD_SEL;
          end
        end else begin
          state_d = S_RD_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d    = (state_d == S_LOAD);
    ctrl_rst_d   = (state_d == S_CLR);
    output_en_d  = (state_d == S_RD_SEL);
    output_sel_d = ridx_d;
    m_valid_d    = (state_d == S_RD_OUT);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers; the controller is held in reset while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      tcnt_q       <= {TCNT_W{1'b0}};
      ridx_q       <= {IDX_W{1'b0}};
      s_ready_q    <= 1'b0;
      ctrl_rst_q   <= 1'b1;
      load_en_q    <= 1'b0;
      load_sel_q   <= 1'b0;
      load_index_q <= {IDX_W{1'b0}};
      in_data_q    <= {DATA_W{1'b0}};
      output_en_q  <= 1'b0;
      output_sel_q <= {IDX_W{1'b0}};
      m_valid_q    <= 1'b0;
      m_data_q     <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      ridx_q       <= ridx_d;
      s_ready_q    <= s_ready_d;
      ctrl_rst_q   <= ctrl_rst_d;
      load_en_q    <= load_en_d;
      load_sel_q   <= load_sel_d;
      load_index_q <= load_index_d;
      in_data_q    <= in_data_d;
      output_en_q  <= output_en_d;
      output_sel_q <= output_sel_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign ctrl_rst    = ctrl_rst_q;
  assign load_en     = load_en_q;
  assign load_sel_ab = load_sel_q;
  assign load_index  = load_index_q;
  assign in_data     = in_data_q;
  assign output_en   = output_en_q;
  assign output_sel  = output_sel_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = busy_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed bench for tpu_host_sequencer with a behavioural controller stub
// (fixed C[i] = 0xA0 + i, or a 2x2 matrix multiply for the integration case).
module tb_tpu_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       ctrl_rst;
  logic       load_en;
  logic       load_sel_ab;
  logic [1:0] load_index;
  logic [7:0] in_data;
  logic       done = 1'b0;
  logic       output_en;
  logic [1:0] output_sel;
  logic [7:0] out_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  // stub state
  bit         never_done = 1'b0;
  bit         mat_mode = 1'b0;
  logic [7:0] a_mem [0:3];
  logic [7:0] b_mem [0:3];
  int         dly = 0;
  int         nload = 0;
  int         cyc = 0;
  logic [10:0] log_w [0:15];
  int          log_c [0:15];
  int          log_n = 0;

  always #5 clk = ~clk;

  tpu_host_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ctrl_rst(ctrl_rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
    .load_index(load_index), .in_data(in_data), .done(done),
    .output_en(output_en), .output_sel(output_sel), .out_data(out_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .timeout(timeout)
  );

  // Controller stub: captures loads, raises done 6 cycles after the 8th load.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ctrl_rst) begin
      nload <= 0;
      dly   <= 0;
      done  <= 1'b0;
      log_n <= 0;
    end else begin
      if (load_en) begin
        if (load_sel_ab) b_mem[load_index] <= in_data;
        else             a_mem[load_index] <= in_data;
        nload <= nload + 1;
        if (nload == 7 && !never_done) dly <= 6;
        if (log_n < 16) begin
          log_w[log_n] <= {load_sel_ab, load_index, in_data};
          log_c[log_n] <= cyc;
          log_n <= log_n + 1;
        end
      end
      if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) done <= 1'b1;
      end
    end
  end

  always_comb begin
    out_data = 8'hA0 + {6'd0, output_sel};
    if (mat_mode) begin
      case (output_sel)
        2'd0: out_data = a_mem[0] * b_mem[0] + a_mem[1] * b_mem[2];
        2'd1: out_data = a_mem[0] * b_mem[1] + a_mem[1] * b_mem[3];
        2'd2: out_data = a_mem[2] * b_mem[0] + a_mem[3] * b_mem[2];
        default: out_data = a_mem[2] * b_mem[1] + a_mem[3] * b_mem[3];
      endcase
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present bytes 1..nb, optionally with random bubbles; returns one cycle after the last handshake.
  task automatic send_job(input int nb, input bit bubbles);
    int idx = 0;
    int guard = 0;
    while (idx < nb && guard < 400) begin
      @(negedge clk);
      guard++;
      if (bubbles && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = 8'(idx + 1);
      end
      if (s_valid && s_ready) idx++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check_vec("send_cnt", idx, nb);
  endtask

  // Collect four result bytes, checking hold-while-stalled, values and busy release.
  task automatic recv_job(input bit toggle);
    logic [7:0] res [0:3];
    logic [7:0] exp_b;
    logic [7:0] held = 8'h00;
    bit   have_held = 1'b0;
    bit   phase = 1'b0;
    int   n = 0;
    int   guard = 0;
    while (n < 4 && guard < 300) begin
      @(negedge clk);
      guard++;
      m_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (have_held) begin
        check_vec("hold_valid", m_valid, 1);
        check_vec("hold_data", m_data, held);
      end
      if (m_valid && m_ready) begin
        res[n] = m_data;
        n++;
        have_held = 1'b0;
      end else if (m_valid) begin
        held = m_data;
        have_held = 1'b1;
      end else begin
        have_held = 1'b0;
      end
    end
    check_vec("res_cnt", n, 4);
    @(negedge clk);
    m_ready = 1'b0;
    check_vec("busy_end", busy, 0);
    check_vec("mvalid_end", m_valid, 0);
    for (int i = 0; i < n; i++) begin
      if (mat_mode) begin
        case (i)
          0: exp_b = 8'd19;
          1: exp_b = 8'd22;
          2: exp_b = 8'd43;
          default: exp_b = 8'd50;
        endcase
      end else begin
        exp_b = 8'(8'hA0 + i);
      end
      check_vec("res_byte", res[i], exp_b);
    end
  endtask

  task automatic check_loads(input bit consec);
    logic [10:0] e;
    logic [2:0]  k;
    check_vec("ld_cnt", log_n, 8);
    for (int i = 0; i < 8 && i < log_n; i++) begin
      k = 3'(i);
      e = {k[2], k[1:0], 8'(i + 1)};
      check_vec("ld_entry", log_w[i], e);
      if (consec && i > 0) check_vec("ld_consec", log_c[i] - log_c[i-1], 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  saw_mv;
    // reset state
    @(negedge clk);
    check_vec("rst_ctrl_rst", ctrl_rst, 1);
    check_vec("rst_busy", busy, 0);
    check_vec("rst_s_ready", s_ready, 0);
    check_vec("rst_m_valid", m_valid, 0);
    check_vec("rst_load_en", load_en, 0);
    check_vec("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_vec("ctrl_rst_rel", ctrl_rst, 0);
    check_vec("idle_s_ready", s_ready, 0);

    // 1: back-to-back bytes, free-flowing output
    send_job(8, 1'b0);
    recv_job(1'b0);
    check_loads(1'b1);

    // 2: stalled output
    send_job(8, 1'b0);
    recv_job(1'b1);
    check_loads(1'b1);

    // 3: input bubbles
    send_job(8, 1'b1);
    recv_job(1'b0);
    check_loads(1'b0);

    // 4: done never arrives
    never_done = 1'b1;
    send_job(8, 1'b0);
    k = 0;
    saw_mv = 1'b0;
    while (!timeout && k < 400) begin
      @(negedge clk);
      k++;
      if (m_valid) saw_mv = 1'b1;
    end
    check_vec("to_flag", timeout, 1);
    check_vec("to_window", (k >= 254 && k <= 257), 1);
    check_vec("to_no_mvalid", saw_mv, 0);
    check_vec("to_busy", busy, 0);
    never_done = 1'b0;
    send_job(8, 1'b0);
    check_vec("to_cleared", timeout, 0);
    recv_job(1'b0);
    check_loads(1'b1);

    // 5: reset in the middle of LOAD
    send_job(3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("mid_ctrl_rst", ctrl_rst, 1);
    check_vec("mid_busy", busy, 0);
    check_vec("mid_s_ready", s_ready, 0);
    check_vec("mid_load_en", load_en, 0);
    check_vec("mid_m_valid", m_valid, 0);
    check_vec("mid_output_en", output_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_job(8, 1'b0);
    recv_job(1'b0);
    check_loads(1'b1);

    // 6: matrix-multiply controller model
    mat_mode = 1'b1;
    send_job(8, 1'b0);
    recv_job(1'b1);
    check_loads(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
